ahb_manager_stream_adapter: RTL and testbench

AHB_MANAGER_STREAM_ADAPTER -- requirements
Module: ahb_manager_stream_adapter

---
 rtl/ahb_manager_pack.sv | 24 ++
 rtl/ahb_stream_fifo.sv | 53 +++++
 rtl/ahb_manager_stream_adapter.sv | 213 +++++++++++++++++++++
 tb/tb_ahb_manager_stream_adapter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_manager_pack.sv
// Shared types for the AHB manager stream adapter: transfer size encoding and adapter FSM states.
package ahb_manager_pack;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3,
    HSIZE_4WORD = 3'd4,
    HSIZE_8WORD = 3'd5,
    HSIZE_16W   = 3'd6,
    HSIZE_32W   = 3'd7
  } t_hsize;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } t_adapter_state;

  localparam int ADDR_WDT = 32;

endpackage

// File: rtl/ahb_stream_fifo.sv
// Read-return FIFO (power-of-two depth). A push while full is taken only when a pop
// happens in the same cycle, so the occupancy never exceeds DEPTH.
module ahb_stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ahb_manager_stream_adapter.sv
// Converts command + write/read streams into AHB manager-UI beats with credit-limited reads.
// Define AHB_STREAM_ADAPTER_RDADDR_EN to carry the beat address through the read FIFO onto o_raddr.
module ahb_manager_stream_adapter
  import ahb_manager_pack::*;
#(
  parameter int DATA_WDT = 32,
  parameter int BEAT_WDT = 16,
  parameter int RD_DEPTH = 4
) (
  input  logic                i_hclk,
  input  logic                i_hreset,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [31:0]         i_cmd_addr,
  input  logic [BEAT_WDT-1:0] i_cmd_len,
  input  logic                i_cmd_wr,
  input  t_hsize              i_cmd_size,
  input  logic                i_wdata_valid,
  output logic                o_wdata_ready,
  input  logic [DATA_WDT-1:0] i_wdata,
  output logic                o_rdata_valid,
  input  logic                i_rdata_ready,
  output logic [DATA_WDT-1:0] o_rdata,
  output logic [31:0]         o_raddr,
  output logic                o_wr,
  output logic                o_rd,
  output logic                o_first_xfer,
  output logic                o_idle,
  output logic [BEAT_WDT-1:0] o_min_len,
  output logic [DATA_WDT-1:0] o_wr_data,
  output logic [31:0]         o_addr,
  output t_hsize              o_size,
  input  logic                i_stall,
  input  logic                i_dav,
  input  logic [DATA_WDT-1:0] i_data,
  input  logic [31:0]         i_addr,
  output logic                o_busy,
  output logic                o_done
);

  localparam int CNT_W = $clog2(RD_DEPTH) + 2;
`ifdef AHB_STREAM_ADAPTER_RDADDR_EN
  localparam int FIFO_W = DATA_WDT + ADDR_WDT;
`else
  localparam int FIFO_W = DATA_WDT;
`endif

  t_adapter_state          state;
  t_adapter_state          next_state;
  logic [31:0]             cmd_addr;
  t_hsize                  cmd_size;
  logic                    cmd_wr;
  logic [BEAT_WDT-1:0]     remaining;
  logic [CNT_W-1:0]        outstanding;
  logic [CNT_W-1:0]        outstanding_next;
  logic                    cmd_fire;
  logic                    load;
  logic                    credit;
  logic                    rd_accept;
  logic                    dav_dec;
  logic                    leave_drain;
  logic                    done_next;
  logic [FIFO_W-1:0]       fifo_wdata;
  logic [FIFO_W-1:0]       fifo_rdata;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(RD_DEPTH):0] fifo_count;
  logic                    fifo_pop;

  assign cmd_fire    = i_cmd_valid & o_cmd_ready;
  assign rd_accept   = o_rd & ~i_stall;
  assign dav_dec     = i_dav & (outstanding != '0);
  // A beat already presented on o_rd also occupies a FIFO slot once it returns.
  assign credit      = (outstanding + CNT_W'(fifo_count) + CNT_W'(o_rd)) < CNT_W'(RD_DEPTH);
  assign leave_drain = ~i_stall & (cmd_wr | (outstanding_next == '0));
  assign o_cmd_ready = (state == ST_IDLE) & ~i_stall & ~i_hreset;
  assign o_idle      = (state == ST_IDLE) | (state == ST_DRAIN);
  assign o_busy      = (state != ST_IDLE);

  always_comb begin
    outstanding_next = outstanding;
    case ({rd_accept, dav_dec})
      2'b10:   outstanding_next = outstanding + CNT_W'(1);
      2'b01:   outstanding_next = outstanding - CNT_W'(1);
      default: outstanding_next = outstanding;
    endcase
  end

  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (cmd_fire && (i_cmd_len != '0)) next_state = ST_FIRST;
        else                               next_state = ST_IDLE;
      end
      ST_FIRST, ST_STREAM: begin
        if (load && (remaining == BEAT_WDT'(1))) next_state = ST_DRAIN;
        else if (load)                           next_state = ST_STREAM;
        else                                     next_state = state;
      end
      ST_DRAIN: begin
        if (leave_drain) next_state = ST_IDLE;
        else             next_state = ST_DRAIN;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // A beat is loaded into the UI registers only on an unstalled edge.
  always_comb begin
    load          = 1'b0;
    o_wdata_ready = 1'b0;
    done_next     = 1'b0;
    case (state)
      ST_IDLE: begin
        done_next = cmd_fire & (i_cmd_len == '0);
      end
      ST_FIRST, ST_STREAM: begin
        load          = ~i_stall & (cmd_wr ? i_wdata_valid : credit);
        o_wdata_ready = ~i_stall & cmd_wr;
      end
      ST_DRAIN: begin
        done_next = leave_drain;
      end
      default: begin
        load = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      cmd_addr    <= 32'd0;
      cmd_size    <= HSIZE_BYTE;
      cmd_wr      <= 1'b0;
      remaining   <= '0;
      outstanding <= '0;
      o_done      <= 1'b0;
    end else begin
      if (cmd_fire) begin
        cmd_addr  <= i_cmd_addr;
        cmd_size  <= i_cmd_size;
        cmd_wr    <= i_cmd_wr;
        remaining <= i_cmd_len;
      end else if (load) begin
        remaining <= remaining - BEAT_WDT'(1);
      end
      outstanding <= outstanding_next;
      o_done      <= done_next;
    end
  end

  // UI outputs only move on edges where the manager is not stalling.
  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      o_wr         <= 1'b0;
      o_rd         <= 1'b0;
      o_first_xfer <= 1'b0;
      o_min_len    <= '0;
      o_addr       <= 32'd0;
      o_size       <= HSIZE_BYTE;
      o_wr_data    <= '0;
    end else if (!i_stall) begin
      o_wr         <= load & cmd_wr;
      o_rd         <= load & ~cmd_wr;
      o_first_xfer <= load & (state == ST_FIRST);
      if (load && (state == ST_FIRST)) begin
        o_min_len <= remaining;
        o_addr    <= cmd_addr;
        o_size    <= cmd_size;
      end
      if (load && cmd_wr) o_wr_data <= i_wdata;
    end
  end

  assign fifo_pop      = o_rdata_valid & i_rdata_ready;
  assign o_rdata_valid = ~fifo_empty;

`ifdef AHB_STREAM_ADAPTER_RDADDR_EN
  assign fifo_wdata = {i_data, i_addr};
  assign o_rdata    = fifo_rdata[FIFO_W-1 -: DATA_WDT];
  assign o_raddr    = fifo_rdata[ADDR_WDT-1:0];
  logic unused_fifo;
  assign unused_fifo = fifo_full;
`else
  assign fifo_wdata = i_data;
  assign o_rdata    = fifo_rdata;
  assign o_raddr    = 32'd0;
  logic unused_fifo;
  assign unused_fifo = fifo_full ^ (^i_addr);
`endif

  ahb_stream_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (RD_DEPTH)
  ) u_rd_fifo (
    .clk   (i_hclk),
    .rst   (i_hreset),
    .push  (i_dav),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_ahb_manager_stream_adapter.sv
// Directed bench for ahb_manager_stream_adapter with a fixed-latency manager model
// (read data equals beat address) and a standalone check of the read-return FIFO.
module tb_ahb_manager_stream_adapter;
  import ahb_manager_pack::*;

  logic        clk = 1'b0;
  logic        i_hreset, i_cmd_valid, o_cmd_ready, i_cmd_wr;
  logic [31:0] i_cmd_addr;
  logic [15:0] i_cmd_len;
  t_hsize      i_cmd_size, o_size;
  logic        i_wdata_valid, o_wdata_ready, o_rdata_valid, i_rdata_ready;
  logic [31:0] i_wdata, o_rdata, o_raddr, o_wr_data, o_addr, i_data, i_addr;
  logic        o_wr, o_rd, o_first_xfer, o_idle, i_stall, i_dav, o_busy, o_done;
  logic [15:0] o_min_len;

  logic        f_push, f_pop, f_full, f_empty;
  logic [7:0]  f_wdata, f_rdata;
  logic [2:0]  f_count;

  always #5 clk = ~clk;

  ahb_manager_stream_adapter #(.DATA_WDT(32), .BEAT_WDT(16), .RD_DEPTH(4)) dut (
    .i_hclk(clk), .i_hreset(i_hreset),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_addr(i_cmd_addr),
    .i_cmd_len(i_cmd_len), .i_cmd_wr(i_cmd_wr), .i_cmd_size(i_cmd_size),
    .i_wdata_valid(i_wdata_valid), .o_wdata_ready(o_wdata_ready), .i_wdata(i_wdata),
    .o_rdata_valid(o_rdata_valid), .i_rdata_ready(i_rdata_ready), .o_rdata(o_rdata), .o_raddr(o_raddr),
    .o_wr(o_wr), .o_rd(o_rd), .o_first_xfer(o_first_xfer), .o_idle(o_idle), .o_min_len(o_min_len),
    .o_wr_data(o_wr_data), .o_addr(o_addr), .o_size(o_size), .i_stall(i_stall), .i_dav(i_dav),
    .i_data(i_data), .i_addr(i_addr), .o_busy(o_busy), .o_done(o_done)
  );

  ahb_stream_fifo #(.WIDTH(8), .DEPTH(4)) u_fifo (
    .clk(clk), .rst(i_hreset), .push(f_push), .wdata(f_wdata), .pop(f_pop),
    .rdata(f_rdata), .full(f_full), .empty(f_empty), .count(f_count)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic        stall_req = 1'b0, rready_req = 1'b0, w_rand = 1'b0;
  int          w_len = 0, w_idx = 0;
  logic [31:0] w_base = 32'd0;

  logic [31:0] wr_seen[$];
  logic        first_seen[$];
  logic [31:0] rd_got[$];
  logic [31:0] raddr_got[$];
  logic [15:0] minlen0;
  int          rd_issued, done_cnt = 0, fire_cyc, done_cyc, ui_seen, stab_err;
  logic        fire_seen, acc_rd_seen, prev_stall = 1'b0;
  logic [31:0] acc_rd_addr, mgr_addr = 32'd0;
  logic        p0_v = 1'b0, p1_v = 1'b0;
  logic [31:0] p0_a = 32'd0, p1_a = 32'd0;
  logic [83:0] snap = '0;

  // One clock: observe at the falling edge, then drive inputs just after the rising edge.
  task automatic tick;
    @(negedge clk);
    cyc++;
    fire_seen = i_cmd_valid & o_cmd_ready;
    if (fire_seen) fire_cyc = cyc;
    if (o_done) begin done_cnt++; done_cyc = cyc; end
    if (o_wr || o_rd) ui_seen++;
    if (i_wdata_valid && o_wdata_ready) w_idx++;
    if (o_wr && !i_stall) begin
      wr_seen.push_back(o_wr_data);
      first_seen.push_back(o_first_xfer);
      if (o_first_xfer) minlen0 = o_min_len;
    end
    acc_rd_seen = o_rd & ~i_stall;
    if (acc_rd_seen) begin
      rd_issued++;
      acc_rd_addr = o_first_xfer ? o_addr : (mgr_addr + (32'd1 << o_size));
      mgr_addr = acc_rd_addr;
    end
    if (o_rdata_valid && i_rdata_ready) begin
      rd_got.push_back(o_rdata);
      raddr_got.push_back(o_raddr);
    end
    if (i_stall && prev_stall &&
        ({o_wr, o_rd, o_first_xfer, o_idle, o_min_len, o_wr_data, o_addr} !== snap)) stab_err++;
    snap = {o_wr, o_rd, o_first_xfer, o_idle, o_min_len, o_wr_data, o_addr};
    prev_stall = i_stall;
    @(posedge clk);
    #1;
    if (fire_seen) i_cmd_valid = 1'b0;
    i_dav = p1_v; i_data = p1_a; i_addr = p1_a;
    p1_v = p0_v; p1_a = p0_a;
    p0_v = acc_rd_seen; p0_a = acc_rd_addr;
    i_wdata = w_base + w_idx;
    i_wdata_valid = (w_idx < w_len) && (!w_rand || ($urandom_range(0, 1) == 1));
    i_stall = stall_req;
    i_rdata_ready = rready_req;
  endtask

  task automatic clear_records;
    wr_seen.delete(); first_seen.delete(); rd_got.delete(); raddr_got.delete();
    rd_issued = 0; ui_seen = 0; stab_err = 0; minlen0 = 16'd0;
  endtask

  task automatic issue_cmd(input logic wr, input logic [31:0] addr, input logic [15:0] len);
    i_cmd_valid = 1'b1; i_cmd_wr = wr; i_cmd_addr = addr; i_cmd_len = len; i_cmd_size = HSIZE_WORD;
    for (int k = 0; k < 20; k++) begin
      tick;
      if (fire_seen) break;
    end
    i_cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    i_hreset = 1'b1;
    tick; tick;
    n_vec++; if (o_idle !== 1'b1) begin n_err++; $display("FAIL reset_idle got %0b want 1", o_idle); end
    n_vec++; if ({o_wr, o_rd, o_first_xfer, o_done, o_busy, o_rdata_valid} !== 6'b0) begin
      n_err++; $display("FAIL reset_flags got %06b want 000000", {o_wr, o_rd, o_first_xfer, o_done, o_busy, o_rdata_valid}); end
    n_vec++; if ({o_cmd_ready, o_wdata_ready} !== 2'b00) begin
      n_err++; $display("FAIL reset_ready got %02b want 00", {o_cmd_ready, o_wdata_ready}); end
    n_vec++; if ({o_min_len, o_addr} !== 48'd0) begin
      n_err++; $display("FAIL reset_len_addr got %0h/%0h want 0/0", o_min_len, o_addr); end
    i_hreset = 1'b0;
    tick;
    n_vec++; if ({o_cmd_ready, o_busy} !== 2'b10) begin
      n_err++; $display("FAIL post_reset_ready got %02b want 10", {o_cmd_ready, o_busy}); end
  endtask

  task automatic test_write_burst;
    int d0, nf;
    clear_records();
    w_base = 32'd0; w_idx = 0; w_len = 8; w_rand = 1'b1;
    i_wdata = 32'd0; i_wdata_valid = 1'b1;
    d0 = done_cnt;
    issue_cmd(1'b1, 32'd0, 16'd8);
    for (int k = 0; k < 400 && done_cnt == d0; k++) tick;
    repeat (5) tick;
    n_vec++; if (wr_seen.size() !== 8) begin n_err++; $display("FAIL wr_beats got %0d want 8", wr_seen.size()); end
    for (int i = 0; i < wr_seen.size(); i++) begin
      n_vec++; if (wr_seen[i] !== 32'(i)) begin n_err++; $display("FAIL wr_data[%0d] got %0h want %0h", i, wr_seen[i], i); end
    end
    nf = 0;
    foreach (first_seen[i]) if (first_seen[i]) nf++;
    n_vec++; if (nf !== 1 || first_seen[0] !== 1'b1) begin
      n_err++; $display("FAIL wr_first got count %0d want 1 on beat 0", nf); end
    n_vec++; if (minlen0 !== 16'd8) begin n_err++; $display("FAIL wr_min_len got %0d want 8", minlen0); end
    n_vec++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL wr_done got %0d want 1", done_cnt - d0); end
    n_vec++; if ({o_busy, o_wr} !== 2'b00) begin n_err++; $display("FAIL wr_end_idle got %02b want 00", {o_busy, o_wr}); end
    w_len = 0;
  endtask

  task automatic test_read_backpressure;
    int d0;
    logic [31:0] exp_ra;
    clear_records();
    rready_req = 1'b0; i_rdata_ready = 1'b0;
    d0 = done_cnt;
    issue_cmd(1'b0, 32'h100, 16'd8);
    repeat (40) tick;
    n_vec++; if (rd_issued !== 4) begin n_err++; $display("FAIL rd_credit_issued got %0d want 4", rd_issued); end
    n_vec++; if ({o_rd, o_rdata_valid, o_busy} !== 3'b011) begin
      n_err++; $display("FAIL rd_blocked got %03b want 011", {o_rd, o_rdata_valid, o_busy}); end
    rready_req = 1'b1;
    for (int k = 0; k < 300 && (rd_got.size() < 8 || done_cnt == d0); k++) tick;
    repeat (3) tick;
    n_vec++; if (rd_got.size() !== 8) begin n_err++; $display("FAIL rd_count got %0d want 8", rd_got.size()); end
    for (int i = 0; i < rd_got.size(); i++) begin
      n_vec++; if (rd_got[i] !== 32'h100 + 32'(4 * i)) begin
        n_err++; $display("FAIL rd_data[%0d] got %0h want %0h", i, rd_got[i], 32'h100 + 32'(4 * i)); end
`ifdef AHB_STREAM_ADAPTER_RDADDR_EN
      exp_ra = 32'h100 + 32'(4 * i);
`else
      exp_ra = 32'h0;
`endif
      n_vec++; if (raddr_got[i] !== exp_ra) begin
        n_err++; $display("FAIL rd_raddr[%0d] got %0h want %0h", i, raddr_got[i], exp_ra); end
    end
    n_vec++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL rd_done got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_stall;
    int d0, n1;
    clear_records();
    w_base = 32'h20; w_idx = 0; w_len = 8; w_rand = 1'b0;
    i_wdata = 32'h20; i_wdata_valid = 1'b1;
    d0 = done_cnt;
    issue_cmd(1'b1, 32'h40, 16'd8);
    for (int k = 0; k < 100 && wr_seen.size() < 3; k++) tick;
    stall_req = 1'b1;
    tick;
    n1 = wr_seen.size();
    stab_err = 0;
    repeat (5) tick;
    n_vec++; if (stab_err !== 0) begin n_err++; $display("FAIL stall_stable got %0d changes want 0", stab_err); end
    n_vec++; if (wr_seen.size() !== n1) begin n_err++; $display("FAIL stall_no_beat got %0d want %0d", wr_seen.size(), n1); end
    n_vec++; if ({o_wdata_ready, o_wr} !== 2'b01) begin
      n_err++; $display("FAIL stall_hold got %02b want 01", {o_wdata_ready, o_wr}); end
    stall_req = 1'b0;
    for (int k = 0; k < 200 && done_cnt == d0; k++) tick;
    n_vec++; if (wr_seen.size() !== 8) begin n_err++; $display("FAIL stall_beats got %0d want 8", wr_seen.size()); end
    for (int i = 0; i < wr_seen.size(); i++) begin
      n_vec++; if (wr_seen[i] !== 32'h20 + 32'(i)) begin
        n_err++; $display("FAIL stall_data[%0d] got %0h want %0h", i, wr_seen[i], 32'h20 + 32'(i)); end
    end
    n_vec++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL stall_done got %0d want 1", done_cnt - d0); end
    w_len = 0;
  endtask

  task automatic test_len_zero;
    int d0;
    clear_records();
    d0 = done_cnt;
    issue_cmd(1'b1, 32'h80, 16'd0);
    repeat (4) tick;
    n_vec++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL len0_done got %0d want 1", done_cnt - d0); end
    n_vec++; if (done_cyc !== fire_cyc + 1) begin
      n_err++; $display("FAIL len0_done_time got %0d want %0d", done_cyc, fire_cyc + 1); end
    n_vec++; if (ui_seen !== 0) begin n_err++; $display("FAIL len0_no_beat got %0d want 0", ui_seen); end
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL len0_busy got %0b want 0", o_busy); end
  endtask

  task automatic test_reset_mid_burst;
    int d0;
    clear_records();
    rready_req = 1'b0;
    issue_cmd(1'b0, 32'h200, 16'd8);
    for (int k = 0; k < 50 && rd_issued < 3; k++) tick;
    i_hreset = 1'b1;
    p0_v = 1'b0; p1_v = 1'b0; i_dav = 1'b0;
    #1;
    n_vec++; if ({o_busy, o_rd, o_rdata_valid, o_idle, o_cmd_ready} !== 5'b00010) begin
      n_err++; $display("FAIL midrst_flags got %05b want 00010", {o_busy, o_rd, o_rdata_valid, o_idle, o_cmd_ready}); end
    n_vec++; if ({o_min_len, o_addr} !== 48'd0) begin
      n_err++; $display("FAIL midrst_len_addr got %0h/%0h want 0/0", o_min_len, o_addr); end
    d0 = done_cnt;
    repeat (3) tick;
    i_hreset = 1'b0;
    tick;
    n_vec++; if (done_cnt !== d0) begin n_err++; $display("FAIL midrst_no_done got %0d want %0d", done_cnt, d0); end
    clear_records();
    rready_req = 1'b1;
    d0 = done_cnt;
    issue_cmd(1'b0, 32'h300, 16'd2);
    for (int k = 0; k < 100 && (rd_got.size() < 2 || done_cnt == d0); k++) tick;
    n_vec++; if (rd_got.size() !== 2) begin n_err++; $display("FAIL midrst_next_count got %0d want 2", rd_got.size()); end
    n_vec++; if (rd_got[0] !== 32'h300 || rd_got[1] !== 32'h304) begin
      n_err++; $display("FAIL midrst_next_data got %0h,%0h want 300,304", rd_got[0], rd_got[1]); end
    n_vec++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL midrst_next_done got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_fifo_full_push_pop;
    f_push = 1'b1;
    for (int i = 0; i < 4; i++) begin
      f_wdata = 8'hA0 + 8'(i);
      tick;
    end
    f_push = 1'b0;
    n_vec++; if ({f_count, f_full, f_rdata} !== {3'd4, 1'b1, 8'hA0}) begin
      n_err++; $display("FAIL fifo_fill got cnt %0d full %0b head %0h want 4 1 a0", f_count, f_full, f_rdata); end
    f_push = 1'b1; f_pop = 1'b1; f_wdata = 8'hA4;
    tick;
    f_push = 1'b0; f_pop = 1'b0;
    n_vec++; if ({f_count, f_full, f_rdata} !== {3'd4, 1'b1, 8'hA1}) begin
      n_err++; $display("FAIL fifo_full_pushpop got cnt %0d full %0b head %0h want 4 1 a1", f_count, f_full, f_rdata); end
    f_pop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (f_rdata !== 8'hA1 + 8'(i)) begin
        n_err++; $display("FAIL fifo_order[%0d] got %0h want %0h", i, f_rdata, 8'hA1 + 8'(i)); end
      tick;
    end
    f_pop = 1'b0;
    n_vec++; if ({f_empty, f_count} !== {1'b1, 3'd0}) begin
      n_err++; $display("FAIL fifo_empty got %0b/%0d want 1/0", f_empty, f_count); end
  endtask

  initial begin
    i_hreset = 1'b1; i_cmd_valid = 1'b0; i_cmd_wr = 1'b0; i_cmd_addr = 32'd0; i_cmd_len = 16'd0;
    i_cmd_size = HSIZE_WORD; i_wdata_valid = 1'b0; i_wdata = 32'd0; i_rdata_ready = 1'b0;
    i_stall = 1'b0; i_dav = 1'b0; i_data = 32'd0; i_addr = 32'd0;
    f_push = 1'b0; f_pop = 1'b0; f_wdata = 8'd0;
    clear_records();
    test_reset();
    test_write_burst();
    test_read_backpressure();
    test_stall();
    test_len_zero();
    test_reset_mid_burst();
    test_fifo_full_push_pop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
